// File: rtl/logic_pkg.sv
// Shared types and constants for the bitwise logic execution unit.
package logic_pkg;

  localparam int OP_W = 3;

  // Operation encodings presented on the op port.
  typedef enum logic [OP_W-1:0] {
    OP_AND     = 3'b000,
    OP_OR      = 3'b001,
    OP_XOR     = 3'b010,
    OP_ANDN    = 3'b011,
    OP_ORN     = 3'b100,
    OP_XNOR    = 3'b101,
    OP_ORC_B   = 3'b110,
    OP_ILLEGAL = 3'b111
  } op_e;

  // Skid buffer occupancy: EMPTY (nothing), BUSY (output reg only), FULL (both).
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_BUSY  = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

  // Payload at the default datapath widths. Field order {y, zero, err, tag}
  // is the packing used by the unit for any WIDTH/TAG_W.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_TAG_W = 5;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] y;
    logic                 zero;
    logic                 err;
    logic [DEF_TAG_W-1:0] tag;
  } payload_t;

endpackage

// File: rtl/logic_skid.sv
// Generic two-entry valid/ready skid buffer.
// Handshake: a word moves on a clock edge when its valid and ready are both
// high; valid never depends on ready, and out_valid/out_data are held stable
// while out_valid is high and out_ready is low. Upstream readiness is
// (state != SKID_FULL), decoded from the state register only, so there is no
// combinational path from out_ready back to the producer.
module logic_skid
  import logic_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output skid_state_e       state
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              accept;
  logic              retire;

  assign accept    = in_valid && (state_q != SKID_FULL);
  assign retire    = out_ready && (state_q != SKID_EMPTY);
  assign out_valid = (state_q != SKID_EMPTY);
  assign out_data  = out_data_q;
  assign state     = state_q;

  // Next-state and data routing for the output and skid registers.
  always_comb begin
    state_d     = state_q;
    out_data_d  = out_data_q;
    skid_data_d = skid_data_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d    = SKID_BUSY;
          out_data_d = in_data;
        end
      end
      SKID_BUSY: begin
        if (accept && retire) begin
          out_data_d = in_data;
        end else if (retire) begin
          state_d = SKID_EMPTY;
        end else if (accept) begin
          state_d     = SKID_FULL;
          skid_data_d = in_data;
        end
      end
      SKID_FULL: begin
        // FULL never accepts; the skid word moves up on retire.
        if (retire) begin
          state_d    = SKID_BUSY;
          out_data_d = skid_data_q;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
  end

  // State and payload registers; reset discards both stored words.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      out_data_q  <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      skid_data_q <= skid_data_d;
    end
  end

endmodule

// File: rtl/logic_unit.sv
// Registered bitwise logic execution unit (AND/OR/XOR/ANDN/ORN/XNOR/ORC.B)
// with a valid/ready handshake on both sides and a two-entry skid buffer.
module logic_unit
  import logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             err,
  output logic [TAG_W-1:0] out_tag
);

  if ((WIDTH % 8 != 0) || (WIDTH < 8)) begin : g_bad_width
    $error("logic_unit: WIDTH must be a multiple of 8 and at least 8");
  end

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             err;
    logic [TAG_W-1:0] tag;
  } unit_payload_t;

  localparam int PAYLOAD_W = $bits(unit_payload_t);

  unit_payload_t in_payload;
  unit_payload_t out_payload;
  logic [WIDTH-1:0] y_c;
  logic             err_c;
  skid_state_e      skid_state;

  // Op decode and datapath; the illegal encoding yields y = 0 with err set.
  always_comb begin
    y_c   = '0;
    err_c = 1'b0;
    case (op_e'(op))
      OP_AND:  y_c = a & b;
      OP_OR:   y_c = a | b;
      OP_XOR:  y_c = a ^ b;
      OP_ANDN: y_c = a & ~b;
      OP_ORN:  y_c = a | ~b;
      OP_XNOR: y_c = ~(a ^ b);
      OP_ORC_B: begin
        for (int i = 0; i < WIDTH / 8; i++) begin
          y_c[i*8 +: 8] = (a[i*8 +: 8] != 8'h00) ? 8'hFF : 8'h00;
        end
      end
      default: begin
        y_c   = '0;
        err_c = 1'b1;
      end
    endcase
  end

  // Bundle the result with its flags and tag as one payload.
  always_comb begin
    in_payload      = '0;
    in_payload.y    = y_c;
    in_payload.zero = (y_c == '0);
    in_payload.err  = err_c;
    in_payload.tag  = tag;
  end

  logic_skid #(
    .DATA_W(PAYLOAD_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload),
    .state    (skid_state)
  );

  assign in_ready = (skid_state != SKID_FULL);
  assign y        = out_payload.y;
  assign zero     = out_payload.zero;
  assign err      = out_payload.err;
  assign out_tag  = out_payload.tag;

endmodule

// File: tb/tb_logic_unit.sv
// Directed bench for logic_unit: hand-computed vectors, inline timing checks
// and an expected-payload queue checked at every retire.
module tb_logic_unit;
  import logic_pkg::*;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int PW    = $bits(payload_t);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             zero;
  logic             err;
  logic [TAG_W-1:0] out_tag;

  logic_unit #(
    .WIDTH(WIDTH),
    .TAG_W(TAG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .tag      (tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .zero     (zero),
    .err      (err),
    .out_tag  (out_tag)
  );

  // Clock and counters
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] sb_exp;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [WIDTH-1:0] ey, input logic ez, input logic ee,
                          input logic [TAG_W-1:0] et);
    payload_t p;
    p.y    = ey;
    p.zero = ez;
    p.err  = ee;
    p.tag  = et;
    exp_q.push_back(p);
  endtask

  // Presents one op and returns just after the edge that accepts it.
  task automatic issue(input op_e o, input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                       input logic [TAG_W-1:0] it, input logic [WIDTH-1:0] ey,
                       input logic ez, input logic ee);
    in_valid = 1'b1;
    op       = o;
    a        = ia;
    b        = ib;
    tag      = it;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        push_exp(ey, ez, ee, it);
        step();
        return;
      end
      step();
    end
    check("accept_timeout", in_ready, 1);
  endtask

  // Scoreboard: every retire must match the oldest expected payload.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        sb_exp = exp_q.pop_front();
        check("sb_payload", {y, zero, err, out_tag}, sb_exp);
      end
    end
  end

  // Vector table for the throughput run
  op_e         tv_op[8];
  logic [31:0] tv_a[8];
  logic [31:0] tv_b[8];
  logic [31:0] tv_y[8];

  initial begin
    tv_op = '{OP_AND, OP_OR, OP_XOR, OP_ANDN, OP_ORN, OP_XNOR, OP_ORC_B, OP_ORC_B};
    tv_a  = '{32'hFFFF_0000, 32'hF0F0_0000, 32'hAAAA_AAAA, 32'hFFFF_0000,
              32'h0000_0000, 32'h0F0F_0F0F, 32'h8000_0001, 32'h0000_0000};
    tv_b  = '{32'h1234_5678, 32'h0000_000F, 32'hFFFF_FFFF, 32'hFF00_FF00,
              32'hFFFF_FFF0, 32'h00FF_00FF, 32'h0000_0000, 32'h1234_5678};
    tv_y  = '{32'h1234_0000, 32'hF0F0_000F, 32'h5555_5555, 32'h00FF_0000,
              32'h0000_000F, 32'hF00F_F00F, 32'hFF00_00FF, 32'h0000_0000};

    // Reset
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    a         = '0;
    b         = '0;
    tag       = '0;
    step();
    step();
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_zero", zero, 0);
    check("rst_err", err, 0);
    check("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);

    // AND, one-cycle latency
    out_ready = 1'b1;
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd7, 32'h00F0_1234, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("and_out_valid", out_valid, 1);
    check("and_y", y, 32'h00F0_1234);
    check("and_zero", zero, 0);
    check("and_err", err, 0);
    check("and_tag", out_tag, 7);
    step();
    check("and_retired", out_valid, 0);

    // ORC_B
    issue(OP_ORC_B, 32'h0001_0080, 32'hFFFF_FFFF, 5'd8, 32'h00FF_00FF, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("orcb_y", y, 32'h00FF_00FF);
    step();

    // XNOR, XOR, illegal back to back
    issue(OP_XNOR, 32'h1234_5678, 32'h1234_5678, 5'd10, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("xnor_y", y, 32'hFFFF_FFFF);
    check("xnor_zero", zero, 0);
    issue(OP_XOR, 32'h1234_5678, 32'h1234_5678, 5'd11, 32'h0, 1'b1, 1'b0);
    check("xor_y", y, 0);
    check("xor_zero", zero, 1);
    check("xor_err", err, 0);
    issue(OP_ILLEGAL, 32'h1234_5678, 32'h1234_5678, 5'd12, 32'h0, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("ill_y", y, 0);
    check("ill_zero", zero, 1);
    check("ill_err", err, 1);
    check("ill_tag", out_tag, 12);
    step();

    // Backpressure: two absorbed, third waits
    out_ready = 1'b0;
    issue(OP_ANDN, 32'hFFFF_0000, 32'hFF00_FF00, 5'd1, 32'h00FF_0000, 1'b0, 1'b0);
    check("bp_first_valid", out_valid, 1);
    check("bp_first_tag", out_tag, 1);
    issue(OP_OR, 32'hF0F0_0000, 32'h0000_000F, 5'd2, 32'hF0F0_000F, 1'b0, 1'b0);
    in_valid = 1'b1;
    op       = OP_XOR;
    a        = 32'hAAAA_AAAA;
    b        = 32'hFFFF_FFFF;
    tag      = 5'd3;
    check("bp_in_ready_full", in_ready, 0);
    check("bp_hold_tag", out_tag, 1);
    step();
    check("bp_in_ready_hold", in_ready, 0);
    check("bp_hold_valid", out_valid, 1);
    check("bp_hold_tag2", out_tag, 1);
    check("bp_hold_y", y, 32'h00FF_0000);
    out_ready = 1'b1;
    step();
    check("bp_ret1_valid", out_valid, 1);
    check("bp_ret1_tag", out_tag, 2);
    check("bp_ret1_in_ready", in_ready, 1);
    push_exp(32'h5555_5555, 1'b0, 1'b0, 5'd3);
    step();
    in_valid = 1'b0;
    check("bp_ret2_valid", out_valid, 1);
    check("bp_ret2_tag", out_tag, 3);
    step();
    check("bp_drained", out_valid, 0);

    // Full throughput: 16 ops on 16 consecutive cycles
    out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      check("tp_in_ready", in_ready, 1);
      issue(tv_op[j % 8], tv_a[j % 8], tv_b[j % 8], 5'(j), tv_y[j % 8],
            tv_y[j % 8] == 32'h0, 1'b0);
      check("tp_out_valid", out_valid, 1);
      check("tp_out_tag", out_tag, j);
    end
    in_valid = 1'b0;
    step();
    check("tp_drained", out_valid, 0);

    // Reset while FULL discards both payloads
    out_ready = 1'b0;
    issue(OP_AND, 32'hFFFF_FFFF, 32'h1111_1111, 5'd20, 32'h1111_1111, 1'b0, 1'b0);
    issue(OP_XNOR, 32'h0, 32'h0, 5'd21, 32'hFFFF_FFFF, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("rf_in_ready_full", in_ready, 0);
    rst_n = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    check("rf_out_valid", out_valid, 0);
    check("rf_in_ready", in_ready, 1);
    check("rf_y", y, 0);
    check("rf_out_tag", out_tag, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rf_no_stale", out_valid, 0);
    end
    issue(OP_ORN, 32'h0, 32'hFFFF_FFF0, 5'd9, 32'h0000_000F, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("rf_after_y", y, 32'h0000_000F);
    check("rf_after_tag", out_tag, 9);
    step();

    // Drain and report
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/logic_unit.md
# logic_unit

Parametrised, registered bitwise logic execution unit for the RISC-V integer datapath. Replaces the single-bit combinational AND gate with a WIDTH-bit unit covering the RV32I/Zbb logical ops (AND, OR, XOR, ANDN, ORN, XNOR, ORC.B). It sits between issue and writeback, with a valid/ready handshake on both sides and a two-entry skid buffer so backpressure never drops or duplicates a result.

## Interface

**Parameters**
- `WIDTH`, default 32: operand and result width. Must be a multiple of 8 and ≥ 8.
- `TAG_W`, default 5: width of the destination-register tag carried alongside each operation.

**Ports**
- `clk` input 1: the single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: an operation is presented.
- `in_ready` output 1: the unit can accept an operation this cycle.
- `op` input 3: operation select; encodings are in `logic_pkg`.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `tag` input TAG_W: destination tag, passed through unchanged.
- `out_valid` output 1: a result is presented.
- `out_ready` input 1: the consumer takes the result this cycle.
- `y` output WIDTH: result.
- `zero` output 1: high when `y` == 0.
- `err` output 1: the `op` encoding was illegal.
- `out_tag` output TAG_W: the tag of the presented result.

## Operation

- **Accept** when `in_valid && in_ready`. **Retire** when `out_valid && out_ready`.
- **Op encodings:**
  - 000 AND: a & b
  - 001 OR: a | b
  - 010 XOR: a ^ b
  - 011 ANDN: a & ~b
  - 100 ORN: a | ~b
  - 101 XNOR: ~(a ^ b)
  - 110 ORC_B: each byte of `y` is 0xFF if the corresponding byte of `a` is nonzero, else 0x00. `b` is ignored.
  - 111 illegal: `y` = 0, `zero` = 1, `err` = 1.
- The result, `zero`, `err` and `tag` are computed combinationally at accept and captured as one payload.
- **Skid state machine:**
  - EMPTY: `out_valid` = 0.
  - BUSY: output register valid, skid register empty.
  - FULL: both valid.
- **Transitions:**
  - EMPTY, accept → BUSY.
  - BUSY, accept with retire → BUSY; the output register takes the new payload.
  - BUSY, retire without accept → EMPTY.
  - BUSY, accept without retire → FULL; the new payload goes to the skid register.
  - FULL, retire → BUSY; the output register takes the skid payload.
  - FULL never accepts.
- `in_ready` = !skid_valid. It is driven from a register, with no combinational path from `out_ready`.
- Outputs hold stable while `out_valid && !out_ready`.
- Strict FIFO order; no payload is lost or duplicated.
- **Reset values** (on any cycle with `rst_n` = 0):
  - `out_valid` = 0 and skid_valid = 0, so the state is EMPTY and `in_ready` = 1 from the next cycle.
  - `y`, `zero`, `err` and `out_tag` = 0.
  - No accept is recorded on a reset cycle.
  - Reset mid-operation discards both stored payloads.

## Timing

- Latency: accept on edge N → `out_valid` = 1 and payload visible after edge N, i.e. 1 cycle.
- Throughput: 1 op per cycle while `out_ready` is held high.
- Backpressure: with `out_ready` = 0, two ops are absorbed. `in_ready` falls the cycle after the second accept.
- After a retire from FULL, `in_ready` rises the cycle after that retire.
- `out_valid` and the payload are driven from registers only.

## Structure

- `logic_pkg` holds:
  - the `op_e` enum with the 3-bit encodings above;
  - the payload struct {y, zero, err, tag};
  - the `OP_W` constant = 3.
- Sub-module `logic_skid`: a generic two-entry valid/ready skid buffer, parametrised by payload width.
- `logic_unit` holds the combinational op decode and datapath, and instantiates `logic_skid`.

## Test plan

All scenarios use WIDTH = 32 and TAG_W = 5.

- **AND:** AND with a = 0xF0F0_1234, b = 0x0FF0_FFFF, tag = 7 → one cycle later `y` = 0x00F0_1234, `zero` = 0, `err` = 0, `out_tag` = 7.
- **ORC_B:** ORC_B with a = 0x0001_0080, b = 0xFFFF_FFFF → `y` = 0x00FF_00FF.
- **XNOR / XOR / illegal op:**
  - XNOR with a = b = 0x1234_5678 → `y` = 0xFFFF_FFFF, `zero` = 0.
  - Next cycle XOR with the same operands → `y` = 0, `zero` = 1.
  - Then op = 111 → `y` = 0, `err` = 1.
- **Backpressure:** hold `out_ready` = 0 and issue tags 1, 2, 3 back-to-back.
  - Tags 1 and 2 are accepted.
  - `in_ready` = 0 while tag 3 waits.
  - Release `out_ready` → results for tags 1, 2, 3 retire in order on consecutive cycles, with no duplicates.
- **Full throughput:** `out_ready` = 1 and 16 consecutive ops → 16 results on 16 consecutive cycles, starting 1 cycle after the first accept.
- **Reset while FULL:** pull `rst_n` low for one cycle while in FULL → the next cycle shows `out_valid` = 0, `in_ready` = 1 and `y` = 0, and the old payloads never appear.
